// File: rtl/fighter_player.sv
// One fighter per side: movement, hit/knockback, jump airtime, wait-regen and KO, updated once per game tick.
// Optional FIGHTER_HIT_STATS_EN adds an 8-bit saturating hits_taken counter.
module fighter_player #(
  parameter int NUM_POS     = 3,
  parameter int POS_W       = 2,
  parameter int HP_W        = 3,
  parameter int HP_MAX      = 5,
  parameter int START_POS   = 2,
  parameter int PUNCH_DMG   = 2,
  parameter int KICK_DMG    = 1,
  parameter int PUNCH_RANGE = 0,
  parameter int KICK_RANGE  = 1,
  parameter int JUMP_TICKS  = 2,
  parameter int REGEN_WAIT  = 2,
  parameter int MIRROR      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [5:0]       own_action,
  input  logic [5:0]       opp_action,
  input  logic [POS_W-1:0] opp_loc,
  output logic [POS_W-1:0] loc,
  output logic [HP_W-1:0]  health,
  output logic             airborne,
  output logic             ko,
  output logic             hit_pulse
`ifdef FIGHTER_HIT_STATS_EN
  ,
  output logic [7:0]       hits_taken
`endif
);

  localparam logic [1:0] S_GROUND = 2'd0;
  localparam logic [1:0] S_AIR    = 2'd1;
  localparam logic [1:0] S_KO     = 2'd2;

  localparam int RC_W = $clog2(REGEN_WAIT + 1);
  localparam int AC_W = $clog2(JUMP_TICKS + 1);

  localparam logic [POS_W-1:0] L_WALL     = POS_W'(NUM_POS - 1);
  localparam logic [POS_W-1:0] L_START    = POS_W'(START_POS);
  localparam logic [POS_W:0]   L_P_RANGE  = (POS_W + 1)'(PUNCH_RANGE);
  localparam logic [POS_W:0]   L_K_RANGE  = (POS_W + 1)'(KICK_RANGE);
  localparam logic [HP_W-1:0]  L_HP_MAX   = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0]  L_P_DMG    = HP_W'(PUNCH_DMG);
  localparam logic [HP_W-1:0]  L_K_DMG    = HP_W'(KICK_DMG);
  localparam logic [RC_W-1:0]  L_RC_LAST  = RC_W'(REGEN_WAIT - 1);
  localparam logic [AC_W-1:0]  L_AIR_INIT = AC_W'(JUMP_TICKS);

  logic [1:0]       r_state, w_state_nxt;
  logic [POS_W-1:0] r_loc, w_loc_nxt;
  logic [HP_W-1:0]  r_hp, w_hp_nxt;
  logic [RC_W-1:0]  r_regen, w_regen_nxt;
  logic [AC_W-1:0]  r_air, w_air_nxt;
  logic             r_hit_pulse;

  // Malformed (zero or multi-hot) actions decode to idle on either side.
  logic w_own_ok, w_opp_ok;
  logic w_own_punch, w_own_kick, w_own_jump, w_own_wait, w_toward, w_away;
  logic w_opp_punch, w_opp_kick;
  logic [POS_W:0] w_dist;
  logic w_in_p, w_in_k, w_punch_hit, w_kick_hit, w_kick_blocked, w_knock;
  logic [HP_W-1:0] w_dmg;

  assign w_own_ok    = $onehot(own_action);
  assign w_opp_ok    = $onehot(opp_action);
  assign w_own_punch = w_own_ok & own_action[0];
  assign w_own_kick  = w_own_ok & own_action[1];
  assign w_own_jump  = w_own_ok & own_action[2];
  assign w_own_wait  = w_own_ok & own_action[3];
  assign w_toward    = w_own_ok & ((MIRROR != 0) ? own_action[4] : own_action[5]);
  assign w_away      = w_own_ok & ((MIRROR != 0) ? own_action[5] : own_action[4]);
  assign w_opp_punch = w_opp_ok & opp_action[0];
  assign w_opp_kick  = w_opp_ok & opp_action[1];

  assign w_dist         = {1'b0, r_loc} + {1'b0, opp_loc};
  assign w_in_p         = (w_dist <= L_P_RANGE);
  assign w_in_k         = (w_dist <= L_K_RANGE);
  assign w_punch_hit    = w_opp_punch & w_in_p;
  assign w_kick_hit     = ~w_punch_hit & w_opp_kick & w_in_k;
  // A punch thrown in punch range cancels an incoming kick entirely.
  assign w_kick_blocked = w_own_punch & w_in_p;
  assign w_knock        = w_punch_hit | (w_kick_hit & ~w_kick_blocked);

  always_comb begin
    w_dmg = '0;
    if (w_punch_hit && !w_own_punch)
      w_dmg = L_P_DMG;
    else if (w_kick_hit && !w_own_kick && !w_kick_blocked)
      w_dmg = L_K_DMG;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_loc_nxt   = r_loc;
    w_hp_nxt    = r_hp;
    w_regen_nxt = r_regen;
    w_air_nxt   = r_air;
    case (r_state)
      S_GROUND: begin
        if (w_knock)
          w_loc_nxt = (r_loc == L_WALL) ? r_loc : r_loc + 1'b1;
        else if (w_toward)
          w_loc_nxt = (r_loc == '0) ? r_loc : r_loc - 1'b1;
        else if (w_away)
          w_loc_nxt = (r_loc == L_WALL) ? r_loc : r_loc + 1'b1;
        else if (w_own_jump) begin
          w_state_nxt = S_AIR;
          w_air_nxt   = L_AIR_INIT;
        end

        if (w_dmg != '0) begin
          w_regen_nxt = '0;
          if (r_hp <= w_dmg) begin
            w_hp_nxt    = '0;
            w_state_nxt = S_KO;
          end else begin
            w_hp_nxt = r_hp - w_dmg;
          end
        end else if (w_knock || !w_own_wait) begin
          w_regen_nxt = '0;
        end else if (r_regen == L_RC_LAST) begin
          w_regen_nxt = '0;
          w_hp_nxt    = (r_hp >= L_HP_MAX) ? r_hp : r_hp + 1'b1;
        end else begin
          w_regen_nxt = r_regen + 1'b1;
        end
      end
      S_AIR: begin
        w_regen_nxt = '0;
        if (r_air <= AC_W'(1)) begin
          w_air_nxt   = '0;
          w_state_nxt = S_GROUND;
        end else begin
          w_air_nxt = r_air - 1'b1;
        end
      end
      default: begin
        w_hp_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_GROUND;
      r_loc       <= L_START;
      r_hp        <= L_HP_MAX;
      r_regen     <= '0;
      r_air       <= '0;
      r_hit_pulse <= 1'b0;
    end else if (tick) begin
      r_state     <= w_state_nxt;
      r_loc       <= w_loc_nxt;
      r_hp        <= w_hp_nxt;
      r_regen     <= w_regen_nxt;
      r_air       <= w_air_nxt;
      r_hit_pulse <= (r_state == S_GROUND) && (w_dmg != '0);
    end else begin
      r_hit_pulse <= 1'b0;
    end
  end

`ifdef FIGHTER_HIT_STATS_EN
  logic [7:0] r_hits;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_hits <= '0;
    else if (tick && r_state == S_GROUND && w_dmg != '0 && r_hits != 8'hFF)
      r_hits <= r_hits + 8'd1;
  end
  assign hits_taken = r_hits;
`endif

  assign loc       = r_loc;
  assign health    = r_hp;
  assign airborne  = (r_state == S_AIR);
  assign ko        = (r_state == S_KO);
  assign hit_pulse = r_hit_pulse;

endmodule

// File: tb/tb_fighter_player.sv
// Directed bench for fighter_player (default parameters, left-side player) with a scoreboard queue.
module tb_fighter_player;

  localparam logic [5:0] A_MR = 6'b100000;
  localparam logic [5:0] A_ML = 6'b010000;
  localparam logic [5:0] A_WT = 6'b001000;
  localparam logic [5:0] A_JP = 6'b000100;
  localparam logic [5:0] A_KK = 6'b000010;
  localparam logic [5:0] A_PU = 6'b000001;
  localparam logic [5:0] A_NO = 6'b000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] own_action = '0;
  logic [5:0] opp_action = '0;
  logic [1:0] opp_loc = '0;
  logic [1:0] loc;
  logic [2:0] health;
  logic       airborne, ko, hit_pulse;
`ifdef FIGHTER_HIT_STATS_EN
  logic [7:0] hits_taken;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [1:0] loc;
    logic [2:0] hp;
    logic       air;
    logic       ko;
    logic       hitp;
  } exp_t;
  exp_t exp_q[$];

  fighter_player dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .own_action(own_action), .opp_action(opp_action), .opp_loc(opp_loc),
    .loc(loc), .health(health), .airborne(airborne), .ko(ko), .hit_pulse(hit_pulse)
`ifdef FIGHTER_HIT_STATS_EN
    , .hits_taken(hits_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] l, input logic [2:0] h,
                            input logic a, input logic k, input logic p);
    exp_t e;
    e.tag = tag; e.loc = l; e.hp = h; e.air = a; e.ko = k; e.hitp = p;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, ".loc"}, 32'(loc), 32'(e.loc));
    chk({e.tag, ".health"}, 32'(health), 32'(e.hp));
    chk({e.tag, ".airborne"}, 32'(airborne), 32'(e.air));
    chk({e.tag, ".ko"}, 32'(ko), 32'(e.ko));
    chk({e.tag, ".hit_pulse"}, 32'(hit_pulse), 32'(e.hitp));
  endtask

  // One game tick: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input string tag, input logic [5:0] own, input logic [5:0] opp,
                      input logic [1:0] ol, input logic [1:0] el, input logic [2:0] eh,
                      input logic ea, input logic ek, input logic ep);
    expect_out(tag, el, eh, ea, ek, ep);
    @(negedge clk);
    own_action = own; opp_action = opp; opp_loc = ol; tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0; own_action = A_NO; opp_action = A_NO;
    check_out();
  endtask

  // A clock with tick low: everything holds and hit_pulse drops.
  task automatic idle(input string tag, input logic [1:0] el, input logic [2:0] eh,
                      input logic ea, input logic ek);
    expect_out(tag, el, eh, ea, ek, 1'b0);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_out("in_reset", 2'd2, 3'd5, 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    // tick low for 10 clks with busy inputs: nothing may change
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      own_action = A_MR; opp_action = A_PU; opp_loc = 2'd0;
    end
    #1;
    own_action = A_NO; opp_action = A_NO;
    expect_out("tick_low_hold", 2'd2, 3'd5, 1'b0, 1'b0, 1'b0);
    check_out();

    step("mr1", A_MR, A_NO, 2'd2, 2'd1, 3'd5, 0, 0, 0);
    step("mr2", A_MR, A_NO, 2'd2, 2'd0, 3'd5, 0, 0, 0);
    step("mr_sat", A_MR, A_NO, 2'd2, 2'd0, 3'd5, 0, 0, 0);
    step("punch_hit", A_WT, A_PU, 2'd0, 2'd1, 3'd3, 0, 0, 1);
    idle("pulse_drop", 2'd1, 3'd3, 0, 0);
    step("kick_vs_kick", A_KK, A_KK, 2'd0, 2'd2, 3'd3, 0, 0, 0);
    step("mr_to_1", A_MR, A_NO, 2'd0, 2'd1, 3'd3, 0, 0, 0);
    step("jump", A_JP, A_NO, 2'd0, 2'd1, 3'd3, 1, 0, 0);
    step("air_kick1", A_MR, A_KK, 2'd0, 2'd1, 3'd3, 1, 0, 0);
    step("air_kick2", A_MR, A_KK, 2'd0, 2'd1, 3'd3, 0, 0, 0);

    step("wait1", A_WT, A_NO, 2'd2, 2'd1, 3'd3, 0, 0, 0);
    step("wait2", A_WT, A_NO, 2'd2, 2'd1, 3'd4, 0, 0, 0);
    step("wait3", A_WT, A_NO, 2'd2, 2'd1, 3'd4, 0, 0, 0);
    step("wait4", A_WT, A_NO, 2'd2, 2'd1, 3'd5, 0, 0, 0);
    step("wait5", A_WT, A_NO, 2'd2, 2'd1, 3'd5, 0, 0, 0);
    step("wait6_sat", A_WT, A_NO, 2'd2, 2'd1, 3'd5, 0, 0, 0);
    step("kick_hit", A_WT, A_KK, 2'd0, 2'd2, 3'd4, 0, 0, 1);
    step("wpw_wait", A_WT, A_NO, 2'd0, 2'd2, 3'd4, 0, 0, 0);
    step("wpw_punch", A_PU, A_NO, 2'd0, 2'd2, 3'd4, 0, 0, 0);
    step("wpw_wait2", A_WT, A_NO, 2'd0, 2'd2, 3'd4, 0, 0, 0);
    step("wpw_wait3", A_WT, A_NO, 2'd0, 2'd2, 3'd5, 0, 0, 0);

    step("invalid_own", 6'b110000, A_NO, 2'd0, 2'd2, 3'd5, 0, 0, 0);
    step("mr_a", A_MR, A_NO, 2'd0, 2'd1, 3'd5, 0, 0, 0);
    step("mr_b", A_MR, A_NO, 2'd0, 2'd0, 3'd5, 0, 0, 0);
    step("invalid_opp", A_NO, 6'b000011, 2'd0, 2'd0, 3'd5, 0, 0, 0);
    step("clash", A_PU, A_PU, 2'd0, 2'd1, 3'd5, 0, 0, 0);
    step("mr_c", A_MR, A_NO, 2'd0, 2'd0, 3'd5, 0, 0, 0);
    step("punch_cancels_kick", A_PU, A_KK, 2'd0, 2'd0, 3'd5, 0, 0, 0);
    step("ml_away", A_ML, A_NO, 2'd0, 2'd1, 3'd5, 0, 0, 0);
    step("mr_d", A_MR, A_NO, 2'd0, 2'd0, 3'd5, 0, 0, 0);
    step("punch_hit2", A_NO, A_PU, 2'd0, 2'd1, 3'd3, 0, 0, 1);
    step("mr_e", A_MR, A_NO, 2'd0, 2'd0, 3'd3, 0, 0, 0);
    step("punch_hit3", A_NO, A_PU, 2'd0, 2'd1, 3'd1, 0, 0, 1);
    step("mr_f", A_MR, A_NO, 2'd0, 2'd0, 3'd1, 0, 0, 0);
    step("ko_kick", A_NO, A_KK, 2'd0, 2'd1, 3'd0, 0, 1, 1);
    step("ko_punch", A_PU, A_PU, 2'd0, 2'd1, 3'd0, 0, 1, 0);
    step("ko_move", A_MR, A_NO, 2'd0, 2'd1, 3'd0, 0, 1, 0);
    step("ko_wait", A_WT, A_NO, 2'd0, 2'd1, 3'd0, 0, 1, 0);
    step("ko_jump", A_JP, A_KK, 2'd0, 2'd1, 3'd0, 0, 1, 0);

`ifdef FIGHTER_HIT_STATS_EN
    chk("hits_taken", 32'(hits_taken), 32'd5);
`endif

    // asynchronous reset asserted in the middle of a tick
    @(negedge clk);
    own_action = A_PU; opp_action = A_PU; tick = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 2'd2, 3'd5, 0, 0, 0);
    check_out();
`ifdef FIGHTER_HIT_STATS_EN
    chk("hits_taken_reset", 32'(hits_taken), 32'd0);
`endif
    @(posedge clk);
    #1;
    expect_out("reset_held", 2'd2, 3'd5, 0, 0, 0);
    check_out();
    tick = 1'b0; own_action = A_NO; opp_action = A_NO;
    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset", A_MR, A_NO, 2'd2, 2'd1, 3'd5, 0, 0, 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fighter_player.md
Name: fighter_player

Overview:
- Parametrised single-fighter state block for the two-player fighting game. Supersedes the fixed 3-position, 2-bit-health player.
- One instance per side; MIRROR selects left or right orientation. Each instance resolves movement, hits, knockback, jump airtime, wait-regeneration and KO once per game tick.
- Inputs are its own action, the opponent's action and the opponent's location. It publishes registered location, health and status to the opponent instance and the display logic.

Parameters:
NUM_POS, 3, positions per side; location 0 = centre line, NUM_POS-1 = outer wall
POS_W, 2, location width; must satisfy 2^POS_W >= NUM_POS
HP_W, 3, health width
HP_MAX, 5, reset and regeneration ceiling for health
START_POS, 2, reset location
PUNCH_DMG, 2, health lost to an unblocked punch
KICK_DMG, 1, health lost to an unblocked kick
PUNCH_RANGE, 0, maximum distance at which a punch lands
KICK_RANGE, 1, maximum distance at which a kick lands
JUMP_TICKS, 2, ticks spent airborne per jump
REGEN_WAIT, 2, consecutive WAIT ticks per +1 health
MIRROR, 0, 0 = left player (MOVE_RIGHT goes toward centre), 1 = right player (MOVE_LEFT goes toward centre)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
tick  in  1  game-step strobe, one clk wide; all state updates happen only on clk edges with tick=1
own_action  in  6  one-hot {MOVE_RIGHT, MOVE_LEFT, WAIT, JUMP, KICK, PUNCH}, bit5..bit0
opp_action  in  6  opponent action, same encoding
opp_loc  in  POS_W  opponent registered location
loc  out  POS_W  own location
health  out  HP_W  own health
airborne  out  1  1 while in state AIR
ko  out  1  1 while in state KO
hit_pulse  out  1  one-clk pulse on the tick damage was taken

Behaviour:
- Reset values: loc=START_POS, health=HP_MAX, state=GROUND, airborne=0, ko=0, hit_pulse=0, regen count=0, air count=0. Reset mid-game restores these immediately.
- All outputs are registered. Results of tick edge N are visible after that edge.
- tick=0: all state holds; hit_pulse=0.
- Invalid action (zero or multi-hot) is treated as idle: no move, no attack, regen count cleared.
- States: GROUND, AIR, KO.
  - KO is terminal until reset; all inputs are ignored and health is held at 0.
- Distance d = loc + opp_loc, computed at POS_W+1 bits using pre-tick values.
- GROUND tick, resolved in this priority order:
  1. Punch resolution: if opp=PUNCH and d<=PUNCH_RANGE:
     - own=PUNCH: clash, knockback only.
     - otherwise: health -= PUNCH_DMG, plus knockback.
  2. Kick resolution, else if opp=KICK and d<=KICK_RANGE:
     - own=KICK: knockback only.
     - own=PUNCH with d<=PUNCH_RANGE: no effect.
     - otherwise: health -= KICK_DMG, plus knockback.
  3. Knockback: loc+1, saturating at NUM_POS-1. It overrides own movement on that tick.
  4. No hit:
     - Toward-centre move: loc-1, saturating at 0.
     - Away move: loc+1, saturating at NUM_POS-1.
     - JUMP: enter AIR with air count = JUMP_TICKS.
- Damage saturates at 0. Reaching 0 enters KO on the same edge, and hit_pulse=1 that tick.
- Regen:
  - Each WAIT tick with no damage increments the regen count.
  - When the count reaches REGEN_WAIT: health+1 (saturating at HP_MAX) and the count clears.
  - Any non-WAIT tick or any hit (including a clash) clears the count.
- AIR tick:
  - Immune to all hits.
  - Own actions are ignored; no movement.
  - Air count decrements; at 0 the state returns to GROUND. JUMP_TICKS=2 means two airborne ticks.
- Clash knockback counts as a hit for regen clearing, but hit_pulse stays 0.

Optional Feature:
- Macro: FIGHTER_HIT_STATS_EN.
- Defined: adds output port hits_taken (8 bits, reset 0). It increments on every damaging tick and saturates at 255.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset with defaults -> loc=2, health=5, ko=0, airborne=0; hold tick=0 for 10 clks -> outputs unchanged.
- MIRROR=0, loc=2, three MOVE_RIGHT ticks -> loc 1, 0, 0 (saturates); opp_loc=0 and opp PUNCH, own WAIT -> health 5->3, loc=1, hit_pulse for one clk.
- d=1, opp KICK: own KICK -> health unchanged, loc+1. Repeat with own JUMP (enters AIR first) -> no damage for 2 ticks, airborne=1 on both, then 0.
- health=3, four WAIT ticks -> health 4, then 5; a fifth and sixth WAIT tick -> stays 5. WAIT, PUNCH, WAIT -> no regen.
- health=1, unblocked kick at d=0 -> health=0, ko=1; later PUNCH/MOVE/WAIT ticks -> all outputs frozen; assert rst_n low mid-tick -> immediate reset values.
- FIGHTER_HIT_STATS_EN defined: 3 damaging ticks plus 1 clash -> hits_taken=3; without the macro the design compiles with no hits_taken port.
